// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array operand feeder.
// Default dimensions, the FSM state encoding and packed matrix types.
package sa_pkg;

  localparam int N     = 3;
  localparam int DW    = 8;
  localparam int ACC_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FEED   = 2'd1,
    FLUSH  = 2'd2,
    RESULT = 2'd3
  } state_t;

  typedef logic [N*N*DW-1:0]    mat_t;
  typedef logic [N*N*ACC_W-1:0] res_t;
  typedef logic [N*DW-1:0]      lane_t;

endpackage

// File: rtl/sa_operand_mux.sv
// Combinational operand selector: column k of A onto the row lanes,
// row k of B onto the column lanes. The caller registers the outputs.
module sa_operand_mux #(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int KW = 2
) (
  input  logic [N*N*DW-1:0] mat_a,
  input  logic [N*N*DW-1:0] mat_b,
  input  logic [KW-1:0]     k,
  output logic [N*DW-1:0]   col_a,
  output logic [N*DW-1:0]   row_b
);

  // lane i of col_a is A[i][k]; lane j of row_b is B[k][j]
  always_comb begin
    col_a = '0;
    row_b = '0;
    for (int i = 0; i < N; i++) begin
      col_a[i*DW +: DW] = mat_a[(i*N + int'(k))*DW +: DW];
      row_b[i*DW +: DW] = mat_b[(int'(k)*N + i)*DW +: DW];
    end
  end

endmodule

// File: rtl/sa_feeder.sv
// Operand feeder / result collector for an N x N systolic array.
// Accepts two matrices, streams A columns and B rows for N cycles, waits
// for the array result, then holds it until the consumer takes it.
// Optional build macro SA_FEEDER_TIMEOUT_EN adds a FLUSH watchdog that
// returns an all-zero result flagged by res_err after TIMEOUT cycles.
module sa_feeder #(
  parameter int N       = sa_pkg::N,
  parameter int DW      = sa_pkg::DW,
  parameter int ACC_W   = sa_pkg::ACC_W,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*N*DW-1:0]    mat_a,
  input  logic [N*N*DW-1:0]    mat_b,
  output logic                 sa_rst_n,
  output logic [N*DW-1:0]      sa_a,
  output logic [N*DW-1:0]      sa_b,
  input  logic [N*N*ACC_W-1:0] sa_c,
  input  logic                 sa_valid,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [N*N*ACC_W-1:0] res_c,
  output logic                 res_err
);

  import sa_pkg::*;

  localparam int            KW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  state_t              state, state_nx;
  logic [KW-1:0]       k;
  logic [KW-1:0]       k_sel;
  logic [N*N*DW-1:0]   a_q, b_q;
  logic [N*N*DW-1:0]   src_a, src_b;
  logic [N*DW-1:0]     col_a, row_b;
  logic                accept;
  logic                feed_last;
  logic                flush_hit;
  logic                wd_hit;

  assign accept    = in_valid && in_ready;
  assign feed_last = (state == FEED) && (k == K_LAST);
  assign flush_hit = (state == FLUSH) && sa_valid;

  // The handshake cycle must already load lane data for k=0, so the mux
  // reads the live inputs in IDLE and the captured copy afterwards.
  assign src_a = (state == IDLE) ? mat_a : a_q;
  assign src_b = (state == IDLE) ? mat_b : b_q;
  assign k_sel = (state == IDLE) ? '0 : k + 1'b1;

  sa_operand_mux #(.N(N), .DW(DW), .KW(KW)) u_mux (
    .mat_a (src_a),
    .mat_b (src_b),
    .k     (k_sel),
    .col_a (col_a),
    .row_b (row_b)
  );

`ifdef SA_FEEDER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd;

  assign wd_hit = (state == FLUSH) && !sa_valid && (wd == WW'(TIMEOUT - 1));

  // watchdog: counts consecutive FLUSH cycles, cleared elsewhere
  always_ff @(posedge clk) begin
    if (rst) begin
      wd <= '0;
    end else if (state == FLUSH) begin
      wd <= wd + 1'b1;
    end else begin
      wd <= '0;
    end
  end

  // error flag: set on watchdog expiry, cleared by a genuine result
  always_ff @(posedge clk) begin
    if (rst) begin
      res_err <= 1'b0;
    end else if (flush_hit) begin
      res_err <= 1'b0;
    end else if (wd_hit) begin
      res_err <= 1'b1;
    end
  end
`else
  assign wd_hit  = 1'b0;
  assign res_err = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = FEED;
      FEED:    if (k == K_LAST) state_nx = FLUSH;
      FLUSH:   if (sa_valid || wd_hit) state_nx = RESULT;
      RESULT:  if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    sa_rst_n  = (state == FEED) || (state == FLUSH);
    res_valid = (state == RESULT);
  end

  // operand capture on handshake (data only, no reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= mat_a;
      b_q <= mat_b;
    end
  end

  // lane streams: k=0 loaded at the handshake, then one step per FEED cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      k    <= '0;
      sa_a <= '0;
      sa_b <= '0;
    end else if (accept) begin
      k    <= '0;
      sa_a <= col_a;
      sa_b <= row_b;
    end else if ((state == FEED) && !feed_last) begin
      k    <= k + 1'b1;
      sa_a <= col_a;
      sa_b <= row_b;
    end else begin
      k    <= '0;
      sa_a <= '0;
      sa_b <= '0;
    end
  end

  // result capture from the array, or zero on watchdog expiry
  always_ff @(posedge clk) begin
    if (rst) begin
      res_c <= '0;
    end else if (flush_hit) begin
      res_c <= sa_c;
    end else if (wd_hit) begin
      res_c <= '0;
    end
  end

endmodule

// File: tb/tb_sa_feeder.sv
// Directed bench for sa_feeder with a behavioural N x N systolic-array
// stand-in that accumulates lane products and raises sa_valid later.
module tb_sa_feeder;

  localparam int N       = 3;
  localparam int DW      = 8;
  localparam int ACC_W   = 16;
  localparam int TIMEOUT = 20;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [N*N*DW-1:0]    mat_a;
  logic [N*N*DW-1:0]    mat_b;
  logic                 sa_rst_n;
  logic [N*DW-1:0]      sa_a;
  logic [N*DW-1:0]      sa_b;
  logic [N*N*ACC_W-1:0] sa_c;
  logic                 sa_valid;
  logic                 res_valid;
  logic                 res_ready;
  logic [N*N*ACC_W-1:0] res_c;
  logic                 res_err;

  sa_feeder #(.N(N), .DW(DW), .ACC_W(ACC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mat_a     (mat_a),
    .mat_b     (mat_b),
    .sa_rst_n  (sa_rst_n),
    .sa_a      (sa_a),
    .sa_b      (sa_b),
    .sa_c      (sa_c),
    .sa_valid  (sa_valid),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_c     (res_c),
    .res_err   (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // array stand-in
  int   acc [N][N];
  int   mcnt = 0;
  logic mvalid = 1'b0;
  bit   silent = 1'b0;
  logic force_valid = 1'b0;

  always @(posedge clk) begin
    if (!sa_rst_n) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          acc[r][c] <= 0;
      mcnt   <= 0;
      mvalid <= 1'b0;
    end else begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          acc[r][c] <= acc[r][c] + int'(sa_a[r*DW +: DW]) * int'(sa_b[c*DW +: DW]);
      mcnt   <= mcnt + 1;
      mvalid <= (mcnt == N + 3) && !silent;
    end
  end

  always @* begin
    sa_c = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        sa_c[(r*N + c)*ACC_W +: ACC_W] = ACC_W'(acc[r][c]);
  end

  assign sa_valid = mvalid | force_valid;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_res(input string tag, output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    chk({tag, "_valid"}, res_valid, 1'b1);
  endtask

  function automatic logic [N*N*DW-1:0] pack_m(input int v[9]);
    logic [N*N*DW-1:0] p;
    p = '0;
    for (int i = 0; i < 9; i++) p[i*DW +: DW] = DW'(v[i]);
    return p;
  endfunction

  function automatic logic [N*N*ACC_W-1:0] pack_c(input int v[9]);
    logic [N*N*ACC_W-1:0] p;
    p = '0;
    for (int i = 0; i < 9; i++) p[i*ACC_W +: ACC_W] = ACC_W'(v[i]);
    return p;
  endfunction

  int seq [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int rev [9] = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
  int exp1[9] = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
  int exp2[9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
  int zer [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    int  cyc;
    bit  seen;

    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
    mat_a = '0; mat_b = '0;
    repeat (3) tick();

    // reset values
    chk("rst_in_ready",  in_ready,  1'b0);
    chk("rst_sa_rst_n",  sa_rst_n,  1'b0);
    chk("rst_sa_a",      sa_a,      '0);
    chk("rst_sa_b",      sa_b,      '0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_c",     res_c,     '0);
    chk("rst_res_err",   res_err,   1'b0);

    rst = 1'b0;
    tick();
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_sa_rst_n", sa_rst_n, 1'b0);

    // sa_valid in IDLE is ignored
    force_valid = 1'b1;
    tick();
    force_valid = 1'b0;
    tick();
    chk("ign_idle_res_valid", res_valid, 1'b0);
    chk("ign_idle_in_ready",  in_ready,  1'b1);

    // run 1: A = B = 1..9; inputs scrambled after handshake
    mat_a = pack_m(seq); mat_b = pack_m(seq); in_valid = 1'b1;
    tick();
    in_valid = 1'b0; mat_a = '0; mat_b = '0;
    chk("r1_k0_sa_a", sa_a, 24'h070401);
    chk("r1_k0_sa_b", sa_b, 24'h030201);
    chk("r1_k0_rstn", sa_rst_n, 1'b1);
    chk("r1_k0_in_ready", in_ready, 1'b0);
    tick();
    chk("r1_k1_sa_a", sa_a, 24'h080502);
    chk("r1_k1_sa_b", sa_b, 24'h060504);
    tick();
    chk("r1_k2_sa_a", sa_a, 24'h090603);
    chk("r1_k2_sa_b", sa_b, 24'h090807);
    tick();
    chk("r1_flush_sa_a", sa_a, '0);
    chk("r1_flush_sa_b", sa_b, '0);
    chk("r1_flush_rstn", sa_rst_n, 1'b1);
    wait_res("r1", cyc);
    chk("r1_res_c",    res_c,    pack_c(exp1));
    chk("r1_res_err",  res_err,  1'b0);
    chk("r1_in_ready", in_ready, 1'b0);
    chk("r1_rstn",     sa_rst_n, 1'b0);

    // hold: result stable with res_ready low, stray sa_valid ignored
    force_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_res_valid", res_valid, 1'b1);
      chk("hold_res_c",     res_c,     pack_c(exp1));
      chk("hold_in_ready",  in_ready,  1'b0);
    end
    force_valid = 1'b0;

    // consume with in_valid high: only RESULT->IDLE is taken
    res_ready = 1'b1; in_valid = 1'b1;
    mat_a = pack_m(seq); mat_b = pack_m(rev);
    tick();
    res_ready = 1'b0;
    chk("cons_res_valid", res_valid, 1'b0);
    chk("cons_in_ready",  in_ready,  1'b1);
    chk("cons_rstn",      sa_rst_n,  1'b0);

    // run 2: accepted one cycle later, B reversed
    tick();
    in_valid = 1'b0;
    chk("r2_in_ready", in_ready, 1'b0);
    chk("r2_k0_sa_a",  sa_a, 24'h070401);
    chk("r2_k0_sa_b",  sa_b, 24'h070809);
    wait_res("r2", cyc);
    chk("r2_res_c",   res_c,   pack_c(exp2));
    chk("r2_res_err", res_err, 1'b0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("r2_done_res_valid", res_valid, 1'b0);

    // reset two cycles into a run
    mat_a = pack_m(seq); mat_b = pack_m(seq); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_sa_a",      sa_a,      '0);
    chk("mrst_sa_b",      sa_b,      '0);
    chk("mrst_rstn",      sa_rst_n,  1'b0);
    chk("mrst_res_valid", res_valid, 1'b0);
    chk("mrst_in_ready",  in_ready,  1'b0);
    chk("mrst_res_c",     res_c,     '0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    chk("mrst_no_result", seen, 1'b0);
    chk("mrst_idle", in_ready, 1'b1);

    // fresh run after reset
    mat_a = pack_m(seq); mat_b = pack_m(seq); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_res("r3", cyc);
    chk("r3_res_c", res_c, pack_c(exp1));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // array that never answers
    silent = 1'b1;
    mat_a = pack_m(seq); mat_b = pack_m(seq); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef SA_FEEDER_TIMEOUT_EN
    wait_res("wd", cyc);
    chk("wd_latency", cyc,     N + TIMEOUT);
    chk("wd_res_err", res_err, 1'b1);
    chk("wd_res_c",   res_c,   pack_c(zer));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("wd_done_res_valid", res_valid, 1'b0);
    chk("wd_done_in_ready",  in_ready,  1'b1);
`else
    repeat (100) tick();
    chk("hang_res_valid", res_valid, 1'b0);
    chk("hang_rstn",      sa_rst_n,  1'b1);
    chk("hang_res_err",   res_err,   1'b0);
    chk("hang_res_c",     res_c,     pack_c(exp1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("hang_rec_in_ready", in_ready, 1'b1);
    chk("hang_rec_res_c",    res_c,    pack_c(zer));
`endif
    silent = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
